// File: rtl/present_mask_pkg.sv
// Shared definitions for the masked PRESENT datapath.
// Holds nibble/share geometry, the fresh-randomness LFSR polynomial,
// the sequencer state encoding and the pLayer bit-index function.
package present_mask_pkg;

  localparam int unsigned NIBBLES    = 16;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SHARE_W    = 64;
  localparam int unsigned RND_W      = 8;
  localparam int unsigned LFSR_W     = 32;
  localparam int unsigned LFSR_STEPS = 8;

  // Galois form of x^32 + x^22 + x^2 + x + 1 (right-shifting).
  localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // pLayer: bit i -> 16*i mod 63, bit 63 fixed.
  // Since 64 == 1 (mod 63), multiplying by 16 is a 4-bit left rotation
  // of the 6-bit index, which also leaves 63 in place.
  function automatic logic [5:0] player_idx(input logic [5:0] i);
    return {i[1:0], i[5:2]};
  endfunction

endpackage

// File: rtl/present_mask_lfsr.sv
// Seeded 32-bit Galois LFSR that advances 8 steps per enabled cycle.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (state -> 1)
//   load, seed - load seed (a zero seed is replaced by 1)
//   en         - advance 8 steps this cycle (load has priority)
//   rnd        - low byte of the current state
module present_mask_lfsr
  import present_mask_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              en,
  output logic [RND_W-1:0]  rnd
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] state_nxt;

  always_comb begin
    state_nxt = state;
    for (int unsigned s = 0; s < LFSR_STEPS; s++) begin
      state_nxt = state_nxt[0] ? ((state_nxt >> 1) ^ LFSR_POLY) : (state_nxt >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_W'(1);
    end else if (load) begin
      state <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  assign rnd = state[RND_W-1:0];

endmodule

// File: rtl/present_sbox_layer_seq.sv
// Nibble-serial sequencer for one PRESENT substitution layer on a
// 3-share masked 64-bit state. Loads three shares, streams one nibble
// per cycle into an external masked S-box pipeline of SBOX_LAT cycles,
// supplies its fresh randomness and collects the returned nibbles.
// Shares are kept strictly separate throughout.
//
// Build option: define PRESENT_PLAYER_EN to write captured bits to their
// pLayer positions; otherwise nibble k lands in bits 4k+3..4k.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - request, honoured only when idle
//   seed                - LFSR seed, loaded on accepted start
//   state_in1/2/3       - input shares, loaded on accepted start
//   sbox_in1/2/3        - nibble shares to the S-box (0 unless feeding)
//   sbox_r              - fresh randomness to the S-box (0 unless busy)
//   sbox_out1/2/3       - nibble shares from the S-box
//   state_out1/2/3      - result shares
//   busy                - accepted start through final capture
//   done                - one-cycle pulse, results valid
module present_sbox_layer_seq
  import present_mask_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 3
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        seed,
  input  logic [63:0]        state_in1,
  input  logic [63:0]        state_in2,
  input  logic [63:0]        state_in3,
  output logic [3:0]         sbox_in1,
  output logic [3:0]         sbox_in2,
  output logic [3:0]         sbox_in3,
  output logic [7:0]         sbox_r,
  input  logic [3:0]         sbox_out1,
  input  logic [3:0]         sbox_out2,
  input  logic [3:0]         sbox_out3,
  output logic [63:0]        state_out1,
  output logic [63:0]        state_out2,
  output logic [63:0]        state_out3,
  output logic               busy,
  output logic               done
);

  localparam logic [SBOX_LAT-1:0] TAIL_MASK = SBOX_LAT'(1) << (SBOX_LAT - 1);

  seq_state_t state_q, state_d;

  logic [3:0]          feed_cnt;
  logic [3:0]          cap_cnt;
  logic [SBOX_LAT-1:0] valid;
  logic                feeding;
  logic                accept;
  logic                capture;
  logic [7:0]          rnd;

  logic [SHARE_W-1:0]  sh1, sh2, sh3;
  logic [SHARE_W-1:0]  res1, res2, res3;

  assign accept  = (state_q == ST_IDLE) && start;
  assign capture = valid[SBOX_LAT-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_FEED;
      ST_FEED:  if (feed_cnt == 4'(NIBBLES - 1)) state_d = ST_DRAIN;
      // Leave once only the tail bit may still be set: that nibble is
      // captured on this edge, so DONE lines up with the final capture.
      ST_DRAIN: if ((valid & ~TAIL_MASK) == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    feeding = (state_q == ST_FEED);
    busy    = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    done    = (state_q == ST_DONE);
  end

  // Shares shift right one nibble per feed cycle; bits 3:0 are the
  // nibble currently presented to the S-box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh1      <= '0;
      sh2      <= '0;
      sh3      <= '0;
      feed_cnt <= '0;
      valid    <= '0;
    end else begin
      if (accept) begin
        sh1 <= state_in1;
        sh2 <= state_in2;
        sh3 <= state_in3;
      end else if (feeding) begin
        sh1 <= sh1 >> NIB_W;
        sh2 <= sh2 >> NIB_W;
        sh3 <= sh3 >> NIB_W;
      end
      if (feeding) begin
        feed_cnt <= feed_cnt + 1'b1;
      end
      valid <= (valid << 1) | SBOX_LAT'(feeding);
    end
  end

  // Result capture, one nibble per share per valid tail bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res1    <= '0;
      res2    <= '0;
      res3    <= '0;
      cap_cnt <= '0;
    end else if (capture) begin
      cap_cnt <= cap_cnt + 1'b1;
`ifdef PRESENT_PLAYER_EN
      for (int unsigned j = 0; j < NIB_W; j++) begin
        res1[player_idx({cap_cnt, j[1:0]})] <= sbox_out1[j[1:0]];
        res2[player_idx({cap_cnt, j[1:0]})] <= sbox_out2[j[1:0]];
        res3[player_idx({cap_cnt, j[1:0]})] <= sbox_out3[j[1:0]];
      end
`else
      res1[{cap_cnt, 2'b00} +: NIB_W] <= sbox_out1;
      res2[{cap_cnt, 2'b00} +: NIB_W] <= sbox_out2;
      res3[{cap_cnt, 2'b00} +: NIB_W] <= sbox_out3;
`endif
    end
  end

  present_mask_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .seed  (seed),
    .en    (busy),
    .rnd   (rnd)
  );

  assign sbox_in1   = feeding ? sh1[NIB_W-1:0] : '0;
  assign sbox_in2   = feeding ? sh2[NIB_W-1:0] : '0;
  assign sbox_in3   = feeding ? sh3[NIB_W-1:0] : '0;
  assign sbox_r     = busy ? rnd : '0;

  assign state_out1 = res1;
  assign state_out2 = res2;
  assign state_out3 = res3;

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Directed bench for present_sbox_layer_seq with a masked S-box model
// of latency LAT: share 1 carries S(x) re-masked by shares 2/3, which
// are the input shares 2/3 XORed with the two nibbles of sbox_r.
`timescale 1ns/1ps
module tb_present_sbox_layer_seq;

  localparam int unsigned LAT       = 3;
  localparam logic [63:0] PLAIN     = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SUB_PLAIN = 64'hC56B_90AD_3EF8_4712;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [63:0] state_in1 = '0, state_in2 = '0, state_in3 = '0;
  logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
  logic [7:0]  sbox_r;
  logic [3:0]  sbox_out1, sbox_out2, sbox_out3;
  logic [63:0] state_out1, state_out2, state_out3;
  logic        busy, done;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  present_sbox_layer_seq #(.SBOX_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .state_in1  (state_in1),
    .state_in2  (state_in2),
    .state_in3  (state_in3),
    .sbox_in1   (sbox_in1),
    .sbox_in2   (sbox_in2),
    .sbox_in3   (sbox_in3),
    .sbox_r     (sbox_r),
    .sbox_out1  (sbox_out1),
    .sbox_out2  (sbox_out2),
    .sbox_out3  (sbox_out3),
    .state_out1 (state_out1),
    .state_out2 (state_out2),
    .state_out3 (state_out3),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  // Masked S-box pipeline model
  logic [3:0] m2, m3;
  logic [3:0] p1 [LAT];
  logic [3:0] p2 [LAT];
  logic [3:0] p3 [LAT];

  always_comb begin
    m2 = sbox_in2 ^ sbox_r[3:0];
    m3 = sbox_in3 ^ sbox_r[7:4];
  end

  always @(posedge clk) begin
    p1[0] <= sbox(sbox_in1 ^ sbox_in2 ^ sbox_in3) ^ m2 ^ m3;
    p2[0] <= m2;
    p3[0] <= m3;
    for (int i = 1; i < LAT; i++) begin
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
      p3[i] <= p3[i-1];
    end
  end

  assign sbox_out1 = p1[LAT-1];
  assign sbox_out2 = p2[LAT-1];
  assign sbox_out3 = p3[LAT-1];

  function automatic logic [63:0] play(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[(16 * i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [63:0] expect_of(input logic [63:0] sub);
`ifdef PRESENT_PLAYER_EN
    return play(sub);
`else
    return sub;
`endif
  endfunction

  function automatic logic [31:0] adv8(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = t[0] ? ((t >> 1) ^ 32'h8020_0003) : (t >> 1);
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] r_seq    [0:63];
  logic [7:0] r_ref    [0:63];
  logic       busy_seq [0:63];
  logic [3:0] in1_seq  [0:63];
  int         done_cyc;
  int         done_cnt;

  // Runs one operation for len cycles starting with start in cycle 0.
  // With glitch set, extra start pulses with junk data land in cycles 5 and 10.
  task automatic run_op(input logic [31:0] sd, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input bit glitch, input int len);
    done_cyc = -1;
    done_cnt = 0;
    for (int cyc = 0; cyc < len; cyc++) begin
      start = (cyc == 0) || (glitch && (cyc == 5 || cyc == 10));
      if (cyc == 0) begin
        seed = sd; state_in1 = a; state_in2 = b; state_in3 = c;
      end else if (start) begin
        seed = 32'hDEAD_BEEF; state_in1 = ~a; state_in2 = 64'h5555_5555_5555_5555; state_in3 = '1;
      end
      r_seq[cyc]    = sbox_r;
      busy_seq[cyc] = busy;
      in1_seq[cyc]  = sbox_in1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      step();
    end
    start = 1'b0;
  endtask

  logic [63:0] rb, rc, held;
  logic [31:0] m;
  int          late_dones;

  initial begin
    // Reset state
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sbox_in", 64'({sbox_in1, sbox_in2, sbox_in3}), 64'd0);
    check("rst_sbox_r", 64'(sbox_r), 64'd0);
    check("rst_out1", state_out1, 64'd0);
    check("rst_out2", state_out2, 64'd0);
    check("rst_out3", state_out3, 64'd0);
    rst_n = 1'b1;
    step();

    // Plain state in share 1 only
    run_op(32'd1, PLAIN, '0, '0, 1'b0, 40);
    check("plain_done_cyc", 64'(done_cyc), 64'd20);
    check("plain_done_cnt", 64'(done_cnt), 64'd1);
    check("busy_c0", 64'(busy_seq[0]), 64'd0);
    check("busy_c1", 64'(busy_seq[1]), 64'd1);
    check("busy_c19", 64'(busy_seq[19]), 64'd1);
    check("busy_c20", 64'(busy_seq[20]), 64'd0);
    check("r_c1", 64'(r_seq[1]), 64'h01);
    check("r_c2", 64'(r_seq[2]), 64'h02);
    check("in1_c1", 64'(in1_seq[1]), 64'hF);
    check("in1_c2", 64'(in1_seq[2]), 64'hE);
    check("in1_c15", 64'(in1_seq[15]), 64'h1);
    check("in1_c17", 64'(in1_seq[17]), 64'h0);
    check("r_idle", 64'(r_seq[30]), 64'h00);
    check("plain_result", state_out1 ^ state_out2 ^ state_out3, expect_of(SUB_PLAIN));
    held = state_out1;
    repeat (5) step();
    check("plain_hold", state_out1, held);

    // Zero seed behaves as seed 1; randomness frozen while idle
    run_op(32'd0, PLAIN, '0, '0, 1'b0, 40);
    m = 32'd1;
    for (int k = 1; k < 20; k++) begin
      check($sformatf("r_seed0_c%0d", k), 64'(r_seq[k]), 64'(m[7:0]));
      r_ref[k] = r_seq[k];
      m = adv8(m);
    end
    check("r_seed0_idle25", 64'(r_seq[25]), 64'h00);
    check("r_seed0_idle39", 64'(r_seq[39]), 64'h00);
    run_op(32'd1, PLAIN, '0, '0, 1'b0, 40);
    for (int k = 1; k < 20; k++) begin
      check($sformatf("r_seed1_c%0d", k), 64'(r_seq[k]), 64'(r_ref[k]));
    end

    // Start pulses while busy are ignored
    run_op(32'd7, PLAIN, '0, '0, 1'b1, 45);
    check("glitch_done_cnt", 64'(done_cnt), 64'd1);
    check("glitch_done_cyc", 64'(done_cyc), 64'd20);
    check("glitch_result", state_out1 ^ state_out2 ^ state_out3, expect_of(SUB_PLAIN));

    // All-zero state: every nibble becomes C
    run_op(32'h1234_5678, '0, '0, '0, 1'b0, 40);
`ifdef PRESENT_PLAYER_EN
    check("zero_result", state_out1 ^ state_out2 ^ state_out3, 64'hFFFF_FFFF_0000_0000);
`else
    check("zero_result", state_out1 ^ state_out2 ^ state_out3, 64'hCCCC_CCCC_CCCC_CCCC);
`endif

    // Back-to-back: next start in the cycle after done
    rb = 64'hA5A5_0F0F_3C3C_9696;
    rc = 64'h1357_9BDF_2468_ACE0;
    run_op(32'd3, PLAIN ^ rb ^ rc, rb, rc, 1'b0, 21);
    check("b2b_first_cyc", 64'(done_cyc), 64'd20);
    run_op(32'd5, PLAIN ^ rc, rc, '0, 1'b0, 40);
    check("b2b_second_cyc", 64'(done_cyc), 64'd20);
    check("b2b_result", state_out1 ^ state_out2 ^ state_out3, expect_of(SUB_PLAIN));

    // Random sharings of the plain state
    for (int n = 0; n < 100; n++) begin
      rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      run_op($urandom, PLAIN ^ rb ^ rc, rb, rc, 1'b0, 22);
      check($sformatf("rand%0d_result", n), state_out1 ^ state_out2 ^ state_out3, expect_of(SUB_PLAIN));
      check($sformatf("rand%0d_share_ne", n),
            64'((state_out1 !== expect_of(SUB_PLAIN)) && (state_out2 !== expect_of(SUB_PLAIN)) &&
                (state_out3 !== expect_of(SUB_PLAIN))), 64'd1);
    end

    // Reset in the middle of an operation
    start = 1'b1; seed = 32'd9; state_in1 = PLAIN; state_in2 = '0; state_in3 = '0;
    step();
    start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_out1", state_out1, 64'd0);
    check("midrst_out2", state_out2, 64'd0);
    check("midrst_out3", state_out3, 64'd0);
    check("midrst_sbox_r", 64'(sbox_r), 64'd0);
    step();
    rst_n = 1'b1;
    late_dones = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (done) late_dones++;
      step();
    end
    check("midrst_no_done", 64'(late_dones), 64'd0);
    check("midrst_out_zero", state_out1 | state_out2 | state_out3, 64'd0);
    run_op(32'd1, PLAIN, '0, '0, 1'b0, 40);
    check("restart_done_cyc", 64'(done_cyc), 64'd20);
    check("restart_result", state_out1 ^ state_out2 ^ state_out3, expect_of(SUB_PLAIN));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
